// File: rtl/day10_record_reader.sv
// Day-10 record reader: parses the machine description byte stream into one
// record at a time (lights, target, button masks, optional joltage targets)
// and presents it on a valid/ready port. Back-to-back records are parsed with
// a single bubble cycle; oversize counts are clamped, and an early tlast ends
// the record as truncated.
//
// state   | meaning
// RD_NL   | waiting for the lights count beat (also idle after end of input)
// RD_TGT  | reading L' target bits
// RD_NB   | waiting for the button count beat
// RD_BTN  | reading B' x L' button bits
// RD_JOLT | reading L' joltage values
// HOLD    | record presented on rec_valid, input stalled
module day10_record_reader #(
  parameter int MAX_NUM_LIGHTS  = 16,
  parameter int MAX_NUM_BUTTONS = 16,
  parameter bit JOLT_EN         = 1'b1,
  parameter int JOLT_W          = 8,
  parameter int AXI_DATA_WIDTH  = 8,
  parameter int NL_W            = $clog2(MAX_NUM_LIGHTS + 1),
  parameter int NB_W            = $clog2(MAX_NUM_BUTTONS + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [AXI_DATA_WIDTH-1:0]             s_tdata,
  input  logic                                  s_tvalid,
  output logic                                  s_tready,
  input  logic                                  s_tlast,
  output logic                                  rec_valid,
  input  logic                                  rec_ready,
  output logic [NL_W-1:0]                       num_lights,
  output logic [NB_W-1:0]                       num_buttons,
  output logic [MAX_NUM_LIGHTS-1:0]             target,
  output logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0] buttons,
  output logic [MAX_NUM_LIGHTS*JOLT_W-1:0]      joltage,
  output logic                                  rec_last,
  output logic                                  end_of_input,
  output logic                                  err_clamp,
  output logic                                  err_trunc
);

  typedef enum logic [2:0] {RD_NL, RD_TGT, RD_NB, RD_BTN, RD_JOLT, HOLD} state_t;

  state_t          state;
  state_t          nat_nxt;   // where the record would go ignoring tlast
  state_t          nxt;
  logic [NL_W-1:0] idx;       // light index within the current field
  logic [NB_W-1:0] bi;        // button index
  logic            beat;
  logic            l_over;
  logic            b_over;
  logic [NL_W-1:0] l_clamped;
  logic [NB_W-1:0] b_clamped;
  logic            li_last;
  logic            btn_done;
  logic            trunc;

  assign beat      = s_tvalid && s_tready;
  assign l_over    = 32'(s_tdata) > MAX_NUM_LIGHTS;
  assign b_over    = 32'(s_tdata) > MAX_NUM_BUTTONS;
  assign l_clamped = l_over ? NL_W'(MAX_NUM_LIGHTS) : NL_W'(s_tdata);
  assign b_clamped = b_over ? NB_W'(MAX_NUM_BUTTONS) : NB_W'(s_tdata);
  assign li_last   = (idx == num_lights - NL_W'(1));
  assign btn_done  = li_last && (bi == num_buttons - NB_W'(1));
  // A tlast beat that is not the record's natural final beat truncates it.
  assign trunc     = beat && s_tlast && (nat_nxt != HOLD);

  // Next-state decode; any accepted tlast beat ends the record.
  always_comb begin
    nat_nxt = state;
    if (beat) begin
      case (state)
        RD_NL:   nat_nxt = (l_clamped != '0) ? RD_TGT : RD_NB;
        RD_TGT:  if (li_last) nat_nxt = RD_NB;
        RD_NB: begin
          if (b_clamped != '0 && num_lights != '0) nat_nxt = RD_BTN;
          else if (JOLT_EN && num_lights != '0)    nat_nxt = RD_JOLT;
          else                                     nat_nxt = HOLD;
        end
        RD_BTN:  if (btn_done) nat_nxt = JOLT_EN ? RD_JOLT : HOLD;
        RD_JOLT: if (li_last) nat_nxt = HOLD;
        default: nat_nxt = state;
      endcase
    end else if (state == HOLD && rec_ready) begin
      nat_nxt = RD_NL;
    end
    nxt = (beat && s_tlast) ? HOLD : nat_nxt;
  end

  // FSM state, handshake outputs and record datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RD_NL;
      s_tready     <= 1'b1;
      rec_valid    <= 1'b0;
      idx          <= '0;
      bi           <= '0;
      num_lights   <= '0;
      num_buttons  <= '0;
      target       <= '0;
      buttons      <= '0;
      joltage      <= '0;
      rec_last     <= 1'b0;
      end_of_input <= 1'b0;
      err_clamp    <= 1'b0;
      err_trunc    <= 1'b0;
    end else begin
      state     <= nxt;
      s_tready  <= (nxt != HOLD);
      rec_valid <= (nxt == HOLD);
      if (beat && s_tlast) rec_last <= 1'b1;
      if (trunc) err_trunc <= 1'b1;
      case (state)
        RD_NL: if (beat) begin
          num_lights  <= l_clamped;
          num_buttons <= '0;
          target      <= '0;
          buttons     <= '0;
          joltage     <= '0;
          rec_last    <= s_tlast;
          idx         <= '0;
          bi          <= '0;
          if (l_over) err_clamp <= 1'b1;
        end
        RD_TGT: if (beat) begin
          for (int i = 0; i < MAX_NUM_LIGHTS; i++)
            if (i == int'(idx)) target[i] <= s_tdata[0];
          idx <= idx + NL_W'(1);
        end
        RD_NB: if (beat) begin
          num_buttons <= b_clamped;
          idx         <= '0;
          if (b_over) err_clamp <= 1'b1;
        end
        RD_BTN: if (beat) begin
          for (int b = 0; b < MAX_NUM_BUTTONS; b++)
            for (int l = 0; l < MAX_NUM_LIGHTS; l++)
              if (b == int'(bi) && l == int'(idx))
                buttons[b*MAX_NUM_LIGHTS + l] <= s_tdata[0];
          if (li_last) begin
            idx <= '0;
            bi  <= bi + NB_W'(1);
          end else begin
            idx <= idx + NL_W'(1);
          end
        end
        RD_JOLT: if (beat && JOLT_EN) begin
          for (int i = 0; i < MAX_NUM_LIGHTS; i++)
            if (i == int'(idx)) joltage[i*JOLT_W +: JOLT_W] <= s_tdata[JOLT_W-1:0];
          idx <= idx + NL_W'(1);
        end
        HOLD: if (rec_ready && rec_last) end_of_input <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_day10_record_reader.sv
// Bench for day10_record_reader with 4 lights / 3 buttons / joltage enabled.
// Records are described abstractly (counts plus random field contents), turned
// into a beat list and an expected record, then streamed into the reader.
module tb_day10_record_reader;
  localparam int ML = 4;
  localparam int MB = 3;
  localparam int JW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic        rec_valid;
  logic        rec_ready = 1'b0;
  logic [2:0]  num_lights;
  logic [1:0]  num_buttons;
  logic [3:0]  target;
  logic [11:0] buttons;
  logic [31:0] joltage;
  logic        rec_last, end_of_input, err_clamp, err_trunc;

  int total = 0;
  int bad = 0;

  // Reference record and its beat list
  logic [8:0]  beats[$];
  logic [2:0]  e_nl;
  logic [1:0]  e_nb;
  logic [3:0]  e_tgt;
  logic [11:0] e_btn;
  logic [31:0] e_jolt;
  logic        e_clamp = 1'b0;

  day10_record_reader #(
    .MAX_NUM_LIGHTS(ML), .MAX_NUM_BUTTONS(MB), .JOLT_EN(1'b1),
    .JOLT_W(JW), .AXI_DATA_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .s_tlast(s_tlast), .rec_valid(rec_valid),
    .rec_ready(rec_ready), .num_lights(num_lights), .num_buttons(num_buttons),
    .target(target), .buttons(buttons), .joltage(joltage), .rec_last(rec_last),
    .end_of_input(end_of_input), .err_clamp(err_clamp), .err_trunc(err_trunc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; rec_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    e_clamp = 1'b0;
  endtask

  // Offer one beat until accepted; stalls = cycles spent with s_tready low.
  task automatic put_beat(input logic [7:0] d, input logic l, output int stalls);
    stalls = 0;
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    while (!s_tready && stalls < 50) begin
      step();
      stalls++;
    end
    if (stalls >= 50) begin
      total++; bad++;
      $display("FAIL put_beat_timeout got=stalled want=accepted");
    end
    step();
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'($urandom);
  endtask

  task automatic send_beats(input int gap_max, output int stalls);
    int st;
    stalls = 0;
    foreach (beats[k]) begin
      if (gap_max > 0 && k > 0) repeat ($urandom_range(gap_max, 0)) step();
      put_beat(beats[k][7:0], beats[k][8], st);
      stalls += st;
    end
  endtask

  // Build a record from raw counts: the reader consumes min(count, max) items.
  task automatic make_rec(input int L, input int B, input bit last);
    int lc, bc;
    logic t;
    logic [7:0] v;
    lc = (L > ML) ? ML : L;
    bc = (B > MB) ? MB : B;
    if (L > ML || B > MB) e_clamp = 1'b1;
    beats.delete();
    e_tgt = '0; e_btn = '0; e_jolt = '0;
    beats.push_back({1'b0, 8'(L)});
    for (int i = 0; i < lc; i++) begin
      t = 1'($urandom); e_tgt[i] = t;
      beats.push_back({1'b0, 7'($urandom), t});
    end
    beats.push_back({1'b0, 8'(B)});
    if (lc > 0) begin
      for (int b = 0; b < bc; b++)
        for (int l = 0; l < lc; l++) begin
          t = 1'($urandom); e_btn[b*ML + l] = t;
          beats.push_back({1'b0, 7'($urandom), t});
        end
      for (int i = 0; i < lc; i++) begin
        v = 8'($urandom); e_jolt[i*JW +: JW] = v;
        beats.push_back({1'b0, v});
      end
    end
    if (last) beats[beats.size()-1][8] = 1'b1;
    e_nl = 3'(lc);
    e_nb = 2'(bc);
  endtask

  task automatic test_reset();
    total++;
    if (s_tready !== 1'b1 || rec_valid !== 1'b0) begin
      bad++; $display("FAIL reset_handshake got=%b%b want=10", s_tready, rec_valid);
    end
    total++;
    if ({num_lights, num_buttons, target, buttons, joltage, rec_last, end_of_input,
         err_clamp, err_trunc} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h/%h/%h/%h/%h want=0", num_lights,
                      num_buttons, target, buttons, joltage);
    end
  endtask

  task automatic test_basic();
    int st;
    beats = '{9'h004, 9'h000, 9'h001, 9'h001, 9'h000, 9'h002,
              9'h001, 9'h000, 9'h000, 9'h001, 9'h000, 9'h001, 9'h001, 9'h000,
              9'h003, 9'h005, 9'h004, 9'h107};
    rec_ready = 1'b1;
    send_beats(0, st);
    total++;
    if (rec_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", rec_valid); end
    total++;
    if (num_lights !== 3'd4 || num_buttons !== 2'd2) begin
      bad++; $display("FAIL basic_counts got=%0d,%0d want=4,2", num_lights, num_buttons);
    end
    total++;
    if (target !== 4'b0110) begin bad++; $display("FAIL basic_target got=%b want=0110", target); end
    total++;
    if (buttons !== 12'h069) begin bad++; $display("FAIL basic_buttons got=%h want=069", buttons); end
    total++;
    if (joltage !== 32'h07040503) begin
      bad++; $display("FAIL basic_joltage got=%h want=07040503", joltage);
    end
    total++;
    if (rec_last !== 1'b1 || end_of_input !== 1'b0) begin
      bad++; $display("FAIL basic_last got=%b%b want=10", rec_last, end_of_input);
    end
    step();
    rec_ready = 1'b0;
    total++;
    if (end_of_input !== 1'b1 || rec_valid !== 1'b0) begin
      bad++; $display("FAIL basic_eoi got=%b%b want=10", end_of_input, rec_valid);
    end
  endtask

  task automatic test_back_to_back();
    int st1, st2;
    rec_ready = 1'b1;
    beats = '{9'h002, 9'h001, 9'h001, 9'h001, 9'h001, 9'h001, 9'h009, 9'h009};
    send_beats(0, st1);
    total++;
    if (rec_valid !== 1'b1 || target !== 4'b0011) begin
      bad++; $display("FAIL b2b_first got=%b,%b want=1,0011", rec_valid, target);
    end
    beats = '{9'h002, 9'h000, 9'h001, 9'h001, 9'h001, 9'h000, 9'h003, 9'h004};
    send_beats(0, st2);
    total++;
    if (st2 !== 1) begin bad++; $display("FAIL b2b_bubble got=%0d want=1", st2); end
    total++;
    if (rec_valid !== 1'b1 || target !== 4'b0010 || buttons !== 12'h001 ||
        joltage !== 32'h00000403) begin
      bad++; $display("FAIL b2b_second got=%b,%b,%h,%h want=1,0010,001,00000403",
                      rec_valid, target, buttons, joltage);
    end
    step();
    rec_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int st;
    make_rec(3, 2, 1'b0);
    send_beats(1, st);
    s_tdata = 8'd2; s_tvalid = 1'b1; rec_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      total++;
      if (s_tready !== 1'b0 || rec_valid !== 1'b1 || target !== e_tgt ||
          buttons !== e_btn || joltage !== e_jolt || num_lights !== e_nl) begin
        bad++; $display("FAIL bp_hold c=%0d got=%b%b %b %h %h want=01 %b %h %h", c,
                        s_tready, rec_valid, target, buttons, joltage, e_tgt, e_btn, e_jolt);
      end
      step();
    end
    rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
    make_rec(2, 1, 1'b0);
    send_beats(0, st);
    total++;
    if (rec_valid !== 1'b1 || num_lights !== e_nl || num_buttons !== e_nb ||
        target !== e_tgt || buttons !== e_btn || joltage !== e_jolt) begin
      bad++; $display("FAIL bp_next got=%b %0d %0d %b %h %h want=1 %0d %0d %b %h %h",
                      rec_valid, num_lights, num_buttons, target, buttons, joltage,
                      e_nl, e_nb, e_tgt, e_btn, e_jolt);
    end
    rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
  endtask

  task automatic test_random();
    int st, L, B, hold;
    for (int r = 0; r < 20; r++) begin
      L = $urandom_range(6, 0);
      B = $urandom_range(4, 0);
      hold = $urandom_range(3, 0);
      make_rec(L, B, 1'b0);
      send_beats(2, st);
      total++;
      if (rec_valid !== 1'b1) begin bad++; $display("FAIL rnd_valid r=%0d got=%b want=1", r, rec_valid); end
      total++;
      if (num_lights !== e_nl || num_buttons !== e_nb) begin
        bad++; $display("FAIL rnd_counts r=%0d got=%0d,%0d want=%0d,%0d", r,
                        num_lights, num_buttons, e_nl, e_nb);
      end
      total++;
      if (target !== e_tgt) begin bad++; $display("FAIL rnd_target r=%0d got=%b want=%b", r, target, e_tgt); end
      total++;
      if (buttons !== e_btn) begin bad++; $display("FAIL rnd_buttons r=%0d got=%h want=%h", r, buttons, e_btn); end
      total++;
      if (joltage !== e_jolt) begin bad++; $display("FAIL rnd_joltage r=%0d got=%h want=%h", r, joltage, e_jolt); end
      total++;
      if (err_clamp !== e_clamp || err_trunc !== 1'b0 || rec_last !== 1'b0) begin
        bad++; $display("FAIL rnd_flags r=%0d got=%b%b%b want=%b00", r, err_clamp,
                        err_trunc, rec_last, e_clamp);
      end
      repeat (hold) begin
        step();
        total++;
        if (s_tready !== 1'b0 || rec_valid !== 1'b1 || target !== e_tgt) begin
          bad++; $display("FAIL rnd_hold r=%0d got=%b%b %b want=01 %b", r, s_tready,
                          rec_valid, target, e_tgt);
        end
      end
      rec_ready = 1'b1;
      step();
      rec_ready = 1'b0;
    end
  endtask

  task automatic test_clamp_empty();
    int st;
    make_rec(6, 2, 1'b0);
    send_beats(0, st);
    total++;
    if (err_clamp !== 1'b1 || num_lights !== 3'd4 || target !== e_tgt || buttons !== e_btn) begin
      bad++; $display("FAIL clamp_lights got=%b %0d %b %h want=1 4 %b %h", err_clamp,
                      num_lights, target, buttons, e_tgt, e_btn);
    end
    rec_ready = 1'b1; step(); rec_ready = 1'b0;
    make_rec(2, 0, 1'b0);
    send_beats(0, st);
    total++;
    if (rec_valid !== 1'b1 || num_buttons !== 2'd0 || buttons !== 12'h000 ||
        target !== e_tgt || joltage !== e_jolt) begin
      bad++; $display("FAIL empty_buttons got=%b %0d %h %b %h want=1 0 000 %b %h", rec_valid,
                      num_buttons, buttons, target, joltage, e_tgt, e_jolt);
    end
    rec_ready = 1'b1; step(); rec_ready = 1'b0;
    make_rec(3, 5, 1'b0);
    send_beats(0, st);
    total++;
    if (num_buttons !== 2'd3 || buttons !== e_btn || err_clamp !== 1'b1) begin
      bad++; $display("FAIL clamp_buttons got=%0d %h %b want=3 %h 1", num_buttons,
                      buttons, err_clamp, e_btn);
    end
    rec_ready = 1'b1; step(); rec_ready = 1'b0;
  endtask

  task automatic test_truncation();
    int st;
    beats = '{9'h004, 9'h0A1, 9'h0F0, 9'h1C3};
    send_beats(0, st);
    total++;
    if (rec_valid !== 1'b1 || err_trunc !== 1'b1 || rec_last !== 1'b1) begin
      bad++; $display("FAIL trunc_flags got=%b%b%b want=111", rec_valid, err_trunc, rec_last);
    end
    total++;
    if (target !== 4'b0101 || num_lights !== 3'd4 || err_clamp !== 1'b0) begin
      bad++; $display("FAIL trunc_target got=%b %0d %b want=0101 4 0", target, num_lights, err_clamp);
    end
    rec_ready = 1'b1; step(); rec_ready = 1'b0;
    total++;
    if (end_of_input !== 1'b1) begin bad++; $display("FAIL trunc_eoi got=%b want=1", end_of_input); end
  endtask

  task automatic test_reset_mid();
    int st;
    make_rec(3, 2, 1'b0);
    for (int k = 0; k < 6; k++) put_beat(beats[k][7:0], beats[k][8], st);
    rst_n = 1'b0;
    step();
    total++;
    if (s_tready !== 1'b1 || rec_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_handshake got=%b%b want=10", s_tready, rec_valid);
    end
    total++;
    if ({num_lights, num_buttons, target, buttons, joltage, rec_last, end_of_input,
         err_clamp, err_trunc} !== '0) begin
      bad++; $display("FAIL rstmid_outputs got=%h/%h/%b/%b want=0", target, buttons,
                      end_of_input, err_trunc);
    end
    rst_n = 1'b1;
    e_clamp = 1'b0;
    make_rec(4, 3, 1'b1);
    send_beats(1, st);
    total++;
    if (rec_valid !== 1'b1 || num_lights !== e_nl || num_buttons !== e_nb ||
        target !== e_tgt || buttons !== e_btn || joltage !== e_jolt || rec_last !== 1'b1) begin
      bad++; $display("FAIL rstmid_record got=%b %0d %0d %b %h %h %b want=1 %0d %0d %b %h %h 1",
                      rec_valid, num_lights, num_buttons, target, buttons, joltage, rec_last,
                      e_nl, e_nb, e_tgt, e_btn, e_jolt);
    end
    rec_ready = 1'b1; step(); rec_ready = 1'b0;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_basic();
    do_reset();
    test_back_to_back();
    test_backpressure();
    test_random();
    do_reset();
    test_clamp_empty();
    do_reset();
    test_truncation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
